// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, control-level constants and fetch FSM state encodings.
package if_fetch_pkg;

    localparam int STALL_W = 6;
    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;

    localparam logic [31:0] ZERO32     = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        JUMP       = 1'b1;
    localparam logic        STALL      = 1'b1;
    localparam logic        ENABLE     = 1'b1;
    localparam logic        DISABLE    = 1'b0;

    typedef enum logic {
        IF_IDLE = 1'b0,
        IF_WAIT = 1'b1
    } if_state_e;

endpackage

// File: rtl/if_fetch_icache.sv
// if_fetch_icache: direct-mapped instruction cache (present only when ICACHE_EN is defined).
// Ports: clk_in/rst_in/rdy_in; rd_addr_i word address looked up combinationally -> hit_o/rd_data_o;
// fill_en_i/fill_addr_i/fill_data_i write one line. Reset clears valid bits only.
`ifdef ICACHE_EN
module if_fetch_icache #(
    parameter int LINES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [29:0] rd_addr_i,
    output logic        hit_o,
    output logic [31:0] rd_data_o,
    input  logic        fill_en_i,
    input  logic [29:0] fill_addr_i,
    input  logic [31:0] fill_data_i
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [IW-1:0]    rd_idx;
    logic [IW-1:0]    fill_idx;

    assign rd_idx    = rd_addr_i[IW-1:0];
    assign fill_idx  = fill_addr_i[IW-1:0];
    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_addr_i[29:IW]);
    assign rd_data_o = data_q[rd_idx];

    always_ff @(posedge clk_in) begin
        if (rst_in) valid_q <= '0;
        else if (rdy_in && fill_en_i) valid_q[fill_idx] <= 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_en_i) begin
            tag_q[fill_idx]  <= fill_addr_i[29:IW];
            data_q[fill_idx] <= fill_data_i;
        end
    end

endmodule
`endif

// File: rtl/if_fetch.sv
// if_fetch: fetch stage; holds PC, fetches words over req/done, presents {instE, pc, inst} to IF/ID.
// Ports: clk_in, rst_in (sync, active-high), rdy_in (global enable), stall_in (bit 1 freezes IF),
// pcJump_in/pcTarget_in redirect, mem_done_in/mem_inst_in memory return, if_req_out/if_addr_out
// memory request, stallReq_out, instE_out/pc_out/inst_out to IF/ID.
// Optional: define ICACHE_EN to add a direct-mapped I-cache of ICACHE_LINES words.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic [STALL_W-1:0] stall_in,
    input  logic               pcJump_in,
    input  logic [ADDR_W-1:0]  pcTarget_in,
    input  logic               mem_done_in,
    input  logic [INST_W-1:0]  mem_inst_in,
    output logic               if_req_out,
    output logic [ADDR_W-1:0]  if_addr_out,
    output logic               stallReq_out,
    output logic               instE_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INST_W-1:0]  inst_out
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, pc_out_q, pc_out_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d, buf_inst_q, buf_inst_d;
    logic              discard_q, discard_d, req_q, req_d, sreq_q, sreq_d;
    logic              inst_e_q, inst_e_d, buf_v_q, buf_v_d;
    logic              stall, done, fill_en, hit;
    logic [INST_W-1:0] hit_inst;

    assign stall = (stall_in[1] == STALL);
    assign done  = (state_q == IF_WAIT) && mem_done_in;

`ifdef ICACHE_EN
    if_fetch_icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rd_addr_i   (pc_q[31:2]),
        .hit_o       (hit),
        .rd_data_o   (hit_inst),
        .fill_en_i   (fill_en),
        .fill_addr_i (addr_q[31:2]),
        .fill_data_i (mem_inst_in)
    );
    logic unused_stall;
    assign unused_stall = ^{stall_in[STALL_W-1:2], stall_in[0]};
`else
    assign hit      = DISABLE;
    assign hit_inst = ZERO32;
    logic unused_cfg;
    assign unused_cfg = ^{ICACHE_LINES, fill_en, stall_in[STALL_W-1:2], stall_in[0]};
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        req_d      = req_q;
        sreq_d     = sreq_q;
        inst_e_d   = stall ? inst_e_q : DISABLE;
        pc_out_d   = pc_out_q;
        inst_out_d = inst_out_q;
        buf_v_d    = buf_v_q;
        buf_inst_d = buf_inst_q;
        fill_en    = DISABLE;
        if (pcJump_in == JUMP) begin
            pc_d     = pcTarget_in;
            inst_e_d = DISABLE;
            buf_v_d  = DISABLE;
            if (done) begin
                state_d = IF_IDLE;
                req_d   = DISABLE;
                sreq_d  = DISABLE;
            end else if (state_q == IF_WAIT) begin
                // the issued request cannot be withdrawn, so its return must be dropped
                discard_d = ENABLE;
            end
        end else if (done) begin
            state_d   = IF_IDLE;
            req_d     = DISABLE;
            sreq_d    = DISABLE;
            discard_d = DISABLE;
            if (!discard_q) begin
                fill_en = ENABLE;
                if (stall) begin
                    // park the word; PC advances when it is finally presented
                    buf_v_d    = ENABLE;
                    buf_inst_d = mem_inst_in;
                end else begin
                    inst_e_d   = ENABLE;
                    pc_out_d   = pc_q;
                    inst_out_d = mem_inst_in;
                    pc_d       = pc_q + 32'd4;
                end
            end
        end else if (state_q == IF_IDLE && !stall) begin
            if (buf_v_q || hit) begin
                inst_e_d   = ENABLE;
                pc_out_d   = pc_q;
                inst_out_d = buf_v_q ? buf_inst_q : hit_inst;
                pc_d       = pc_q + 32'd4;
                buf_v_d    = DISABLE;
            end else begin
                state_d = IF_WAIT;
                req_d   = ENABLE;
                sreq_d  = ENABLE;
                addr_d  = pc_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in == RST_ENABLE) begin
            state_q    <= IF_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= ZERO32;
            discard_q  <= DISABLE;
            req_q      <= DISABLE;
            sreq_q     <= DISABLE;
            inst_e_q   <= DISABLE;
            pc_out_q   <= ZERO32;
            inst_out_q <= ZERO32;
            buf_v_q    <= DISABLE;
            buf_inst_q <= ZERO32;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            req_q      <= req_d;
            sreq_q     <= sreq_d;
            inst_e_q   <= inst_e_d;
            pc_out_q   <= pc_out_d;
            inst_out_q <= inst_out_d;
            buf_v_q    <= buf_v_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign if_req_out   = req_q;
    assign if_addr_out  = addr_q;
    assign stallReq_out = sreq_q;
    assign instE_out    = inst_e_q;
    assign pc_out       = pc_out_q;
    assign inst_out     = inst_out_q;

endmodule
